// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback-path, load-return and regfile-write signals around
// the register-file write-port arbiter.
interface wb_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_waddr;
    logic [DW-1:0] ld_wdata;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          ld_pending;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, ld_valid, ld_waddr, ld_wdata,
        output ld_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, ld_pending
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, ld_valid, ld_waddr, ld_wdata,
        input  ld_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, ld_pending
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the writeback path (priority) and a
// small FIFO of late load returns, with WAW kill and a starvation stall.
module wb_port_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic             alive_vec [DEPTH];
    logic [AW-1:0]    addr_vec  [DEPTH];
    logic [DW-1:0]    data_vec  [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              pipe_stall_q, pipe_stall_d;
    logic              rf_we_q, rf_we_d;
    logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]     rf_wdata_q, rf_wdata_d;

    logic head_valid;
    logic head_alive;
    logic push;
    logic pop;
    logic load_grant;
    logic head_denied;
    logic ld_kill;

    assign head_valid  = (count_q != '0);
    assign head_alive  = alive_vec[rd_ptr_q];
    // Space comes from the registered count only; a same-cycle pop never frees a slot.
    assign bus.ld_ready = rst_n && (count_q != CNT_W'(DEPTH));
    assign push        = bus.ld_valid && bus.ld_ready;
    assign load_grant  = head_valid && head_alive && !bus.pipe_we;
    assign pop         = head_valid && (!head_alive || !bus.pipe_we);
    assign head_denied = head_valid && head_alive && bus.pipe_we;
    // An incoming load is always older than the concurrent pipe write.
    assign ld_kill     = bus.pipe_we && (bus.ld_waddr == bus.pipe_waddr);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic          alive_q, alive_d;
            logic [AW-1:0] addr_q, addr_d;
            logic [DW-1:0] data_q, data_d;
            logic          wr_sel;
            logic          kill;

            assign wr_sel = push && (wr_ptr_q == PTR_W'(gi));
            assign kill   = bus.pipe_we && (addr_q == bus.pipe_waddr);

            always_comb begin
                alive_d = alive_q && !kill;
                addr_d  = addr_q;
                data_d  = data_q;
                if (wr_sel) begin
                    alive_d = !ld_kill;
                    addr_d  = bus.ld_waddr;
                    data_d  = bus.ld_wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    alive_q <= 1'b0;
                end else begin
                    alive_q <= alive_d;
                end
                addr_q <= addr_d;
                data_q <= data_d;
            end

            assign alive_vec[gi] = alive_q;
            assign addr_vec[gi]  = addr_q;
            assign data_vec[gi]  = data_q;
        end
    endgenerate

    always_comb begin
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        pipe_stall_d = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        if (pop) begin
            wait_cnt_d = '0;
        end else if (head_denied) begin
            if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                pipe_stall_d = 1'b1;
                wait_cnt_d   = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (bus.pipe_we) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.pipe_waddr;
            rf_wdata_d = bus.pipe_wdata;
        end else if (load_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_vec[rd_ptr_q];
            rf_wdata_d = data_vec[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wait_cnt_q   <= '0;
            pipe_stall_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wait_cnt_q   <= wait_cnt_d;
            pipe_stall_q <= pipe_stall_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign bus.pipe_stall = pipe_stall_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.ld_pending = head_valid;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model feeds a scoreboard of
// expected regfile writes that an independent monitor checks.
module tb_wb_port_arbiter;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            alive;
    } ent_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    ent_t mq[$];
    wr_t  sb[$];
    int   m_wait  = 0;
    bit   m_stall = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   failures = 0;
    bit   mon_en  = 1'b0;

    bit            lp_v = 1'b0;
    logic [AW-1:0] lp_a = '0;
    logic [DW-1:0] lp_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every regfile write must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL rf_missing actual=no_write required=r%0d<=0x%0h in cycle %0d",
                         sb[0].addr, sb[0].data, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (bus.rf_we) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL rf_unexpected actual=r%0d<=0x%0h required=no_write (cycle %0d)",
                             bus.rf_waddr, bus.rf_wdata, cyc);
                end else begin
                    check("rf_waddr", 64'(bus.rf_waddr), 64'(sb[0].addr));
                    check("rf_wdata", 64'(bus.rf_wdata), 64'(sb[0].data));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // One clock cycle: drive inputs, check status outputs, advance the reference model.
    task automatic step(input bit r, input bit pwe, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pd, input bit lv, input logic [AW-1:0] la,
                        input logic [DW-1:0] ldd, output bit acc);
        bit next_stall;
        next_stall = 1'b0;
        @(negedge clk);
        rst_n          = r;
        bus.pipe_we    = pwe;
        bus.pipe_waddr = pa;
        bus.pipe_wdata = pd;
        bus.ld_valid   = lv;
        bus.ld_waddr   = la;
        bus.ld_wdata   = ldd;
        #1;
        check("ld_ready", 64'(bus.ld_ready), 64'(r && mq.size() < DEPTH));
        check("pipe_stall", 64'(bus.pipe_stall), 64'(m_stall));
        check("ld_pending", 64'(bus.ld_pending), 64'(mq.size() != 0));
        acc = r && lv && (mq.size() < DEPTH);
        if (!r) begin
            mq.delete();
            m_wait  = 0;
            m_stall = 1'b0;
        end else begin
            if (pwe) sb.push_back(wr_t'{cyc + 1, pa, pd});
            if (mq.size() > 0) begin
                if (!mq[0].alive) begin
                    void'(mq.pop_front());
                    m_wait = 0;
                end else if (!pwe) begin
                    sb.push_back(wr_t'{cyc + 1, mq[0].addr, mq[0].data});
                    void'(mq.pop_front());
                    m_wait = 0;
                end else if (m_wait == MAX_WAIT - 1) begin
                    next_stall = 1'b1;
                    m_wait     = 0;
                end else begin
                    m_wait++;
                end
            end
            if (pwe) begin
                foreach (mq[i]) if (mq[i].addr == pa) mq[i].alive = 1'b0;
            end
            if (acc) mq.push_back(ent_t'{la, ldd, !(pwe && la == pa)});
            m_stall = next_stall;
        end
    endtask

    task automatic run(input bit r, input bit pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
        bit acc;
        step(r, pwe, pa, pd, lp_v, lp_a, lp_d, acc);
        if (acc) lp_v = 1'b0;
    endtask

    task automatic queue_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        lp_v = 1'b1;
        lp_a = a;
        lp_d = d;
    endtask

    initial begin
        int nloads;
        bit r;
        bit pwe;
        bus.pipe_we    = 1'b0;
        bus.pipe_waddr = '0;
        bus.pipe_wdata = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_waddr   = '0;
        bus.ld_wdata   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rf_we", 64'(bus.rf_we), 64'd0);
        check("reset_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        check("reset_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        check("reset_pipe_stall", 64'(bus.pipe_stall), 64'd0);
        check("reset_ld_pending", 64'(bus.ld_pending), 64'd0);
        check("reset_ld_ready", 64'(bus.ld_ready), 64'd0);
        mon_en = 1'b1;

        // Pipe write into an empty FIFO
        run(1, 1, 5'd3, 32'h11);
        repeat (2) run(1, 0, 0, 0);

        // Lone load on an idle pipe
        queue_load(5'd5, 32'hAA);
        repeat (4) run(1, 0, 0, 0);

        // Starvation: pipe busy every cycle except the forced stall
        queue_load(5'd9, 32'h99);
        for (int i = 0; i < 9; i++) run(1, !m_stall, 5'd1, 32'h100 + i);
        repeat (2) run(1, 0, 0, 0);

        // Full FIFO holds a third load until a pop
        nloads = 0;
        for (int i = 0; i < 16; i++) begin
            if (!lp_v && nloads < 3) begin
                queue_load(5'(10 + nloads), 32'h200 + nloads);
                nloads++;
            end
            run(1, !m_stall, 5'd2, 32'h300 + i);
        end
        repeat (3) run(1, 0, 0, 0);

        // WAW kill of a queued load
        queue_load(5'd7, 32'h55);
        run(1, 1, 5'd1, 32'h01);
        run(1, 1, 5'd7, 32'h22);
        repeat (3) run(1, 0, 0, 0);

        // Reset with a full FIFO
        queue_load(5'd11, 32'h1);
        run(1, 1, 5'd2, 32'h400);
        queue_load(5'd12, 32'h2);
        run(1, 1, 5'd2, 32'h401);
        run(0, 0, 0, 0);
        lp_v = 1'b0;
        run(1, 0, 0, 0);
        check("post_reset_rf_we", 64'(bus.rf_we), 64'd0);
        repeat (2) run(1, 0, 0, 0);

        // Randomized traffic over a narrow address range to provoke kills
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) != 0);
            if (!lp_v && $urandom_range(0, 1) == 1) queue_load(5'($urandom_range(0, 3)), $urandom);
            pwe = ($urandom_range(0, 1) == 1);
            if (m_stall && $urandom_range(0, 7) != 0) pwe = 1'b0;
            run(r, pwe, 5'($urandom_range(0, 3)), $urandom);
        end

        lp_v = 1'b0;
        repeat (10) run(1, 0, 0, 0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
